// File: rtl/bcd_ex3_pkg.sv
// -----------------------------------------------------------------------------
// bcd_ex3_pkg
// Shared types and constants for the BCD-to-excess-3 stuck-at monitor.
//   state_t     : alarm FSM state, 2-bit encoding exported on the state port
//   EX3_OFFSET  : excess-3 offset added to every valid BCD digit
//   BCD_MAX     : largest legal BCD digit value
// -----------------------------------------------------------------------------
package bcd_ex3_pkg;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_SUSPECT = 2'b01,
      ST_FAULTY  = 2'b10
   } state_t;

   localparam logic [3:0] EX3_OFFSET = 4'd3;
   localparam logic [3:0] BCD_MAX    = 4'd9;

endpackage

// File: rtl/bcd_ex3_sa_monitor_if.sv
// -----------------------------------------------------------------------------
// bcd_ex3_sa_monitor_if
// Valid/ready word interface of the stuck-at monitor.
//   master : producer/consumer side (testbench or self-test block)
//            drives in_valid, din, q, out_ready
//   slave  : the monitor; drives in_ready, out_valid, dout, sa0_map,
//            sa1_map, bad_digit
// -----------------------------------------------------------------------------
interface bcd_ex3_sa_monitor_if #(
   parameter int DIGITS = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [4*DIGITS-1:0]   din;
   logic [4*DIGITS-1:0]   q;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   dout;
   logic [4*DIGITS-1:0]   sa0_map;
   logic [4*DIGITS-1:0]   sa1_map;
   logic [DIGITS-1:0]     bad_digit;

   modport master (
      output in_valid, din, q, out_ready,
      input  in_ready, out_valid, dout, sa0_map, sa1_map, bad_digit
   );

   modport slave (
      input  in_valid, din, q, out_ready,
      output in_ready, out_valid, dout, sa0_map, sa1_map, bad_digit
   );
endinterface

// File: rtl/bcd_ex3_digit.sv
// -----------------------------------------------------------------------------
// bcd_ex3_digit
// Combinational reference for one BCD digit.
//   d   : BCD digit in
//   q   : observed excess-3 nibble from the converter under test
//   ex3 : expected excess-3 nibble (0000 for an illegal digit)
//   sa0 : expected 1, observed 0
//   sa1 : expected 0, observed 1 (only with SA1_DETECT_EN, else 0)
//   bad : digit is greater than 9
// Build option: define SA1_DETECT_EN to enable stuck-at-1 detection.
// -----------------------------------------------------------------------------
module bcd_ex3_digit
   import bcd_ex3_pkg::*;
(
   input  logic [3:0] d,
   input  logic [3:0] q,
   output logic [3:0] ex3,
   output logic [3:0] sa0,
   output logic [3:0] sa1,
   output logic       bad
);

   assign bad = (d > BCD_MAX);
   // An illegal digit has no meaningful reference; expected nibble is zero,
   // which also forces its sa0 bits to zero.
   assign ex3 = bad ? 4'd0 : d + EX3_OFFSET;
   assign sa0 = ex3 & ~q;

`ifdef SA1_DETECT_EN
   assign sa1 = bad ? 4'd0 : (~ex3 & q);
`else
   assign sa1 = 4'd0;
`endif

endmodule

// File: rtl/bcd_ex3_sa_monitor.sv
// -----------------------------------------------------------------------------
// bcd_ex3_sa_monitor
// Multi-digit BCD-to-excess-3 reference converter that checks an external
// converter's output for per-bit stuck-at faults and tracks fault history.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : synchronous clear of sticky map, counter and alarm FSM
//   bus (slave)  : in_valid/in_ready/din/q in, out_valid/out_ready/dout/
//                  sa0_map/sa1_map/bad_digit out (1-cycle registered result)
//   fault_sticky : OR of all fault maps since reset/clr
//   fault_cnt    : saturating count of faulty words
//   state, alarm : alarm FSM state (OK/SUSPECT/FAULTY), alarm = FAULTY
// Build option: define SA1_DETECT_EN to enable stuck-at-1 detection.
// -----------------------------------------------------------------------------
module bcd_ex3_sa_monitor
   import bcd_ex3_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int THRESH = 3,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   bcd_ex3_sa_monitor_if.slave   bus,
   output logic [4*DIGITS-1:0]   fault_sticky,
   output logic [CNT_W-1:0]      fault_cnt,
   output logic [1:0]            state,
   output logic                  alarm
);

   localparam int W     = 4 * DIGITS;
   localparam int RUN_W = $clog2(THRESH + 1);
   localparam logic [RUN_W-1:0] THRESH_R = RUN_W'(THRESH);

   logic [W-1:0]      ex3_w, sa0_w, sa1_w;
   logic [DIGITS-1:0] bad_w;
   logic              accept, faulty, clean;
   state_t            st;
   logic [RUN_W-1:0]  run;
   logic [RUN_W-1:0]  run_inc;

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      bcd_ex3_digit u_digit (
         .d   (bus.din[4*k +: 4]),
         .q   (bus.q[4*k +: 4]),
         .ex3 (ex3_w[4*k +: 4]),
         .sa0 (sa0_w[4*k +: 4]),
         .sa1 (sa1_w[4*k +: 4]),
         .bad (bad_w[k])
      );
   end

   assign bus.in_ready = !bus.out_valid | bus.out_ready;
   assign accept       = bus.in_valid & bus.in_ready;
   assign faulty       = |(sa0_w | sa1_w);
   // A word carrying only bad digits is neither faulty nor clean.
   assign clean        = !faulty && !(|bad_w);
   assign run_inc      = run + 1'b1;
   assign state        = st;

   // Result register: holds while stalled, drops valid after a transfer.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.dout      <= '0;
         bus.sa0_map   <= '0;
         bus.sa1_map   <= '0;
         bus.bad_digit <= '0;
      end else if (accept) begin
         bus.out_valid <= 1'b1;
         bus.dout      <= ex3_w;
         bus.sa0_map   <= sa0_w;
         bus.sa1_map   <= sa1_w;
         bus.bad_digit <= bad_w;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

   // Fault history and alarm FSM; clr overrides a coinciding accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_sticky <= '0;
         fault_cnt    <= '0;
         st           <= ST_OK;
         run          <= '0;
         alarm        <= 1'b0;
      end else if (clr) begin
         fault_sticky <= '0;
         fault_cnt    <= '0;
         st           <= ST_OK;
         run          <= '0;
         alarm        <= 1'b0;
      end else if (accept) begin
         fault_sticky <= fault_sticky | sa0_w | sa1_w;
         if (faulty && fault_cnt != {CNT_W{1'b1}})
            fault_cnt <= fault_cnt + 1'b1;
         unique case (st)
            ST_OK: begin
               if (faulty) begin
                  run <= RUN_W'(1);
                  if (THRESH == 1) begin
                     st    <= ST_FAULTY;
                     alarm <= 1'b1;
                  end else begin
                     st    <= ST_SUSPECT;
                  end
               end
            end
            ST_SUSPECT: begin
               if (faulty) begin
                  run <= run_inc;
                  if (run_inc >= THRESH_R) begin
                     st    <= ST_FAULTY;
                     alarm <= 1'b1;
                  end
               end else if (clean) begin
                  st  <= ST_OK;
                  run <= '0;
               end
            end
            ST_FAULTY: ;
            default: begin
               st    <= ST_OK;
               run   <= '0;
               alarm <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/bcd_ex3_sa_monitor.md
Name: bcd_ex3_sa_monitor

Overview:
- Multi-digit BCD-to-excess-3 reference converter with per-bit stuck-at fault checking of an external converter's output `q`.
- Each accepted word is converted digit-wise to excess-3 (digit+3) and compared bitwise against `q`. Per-bit SA0 (and optionally SA1) maps are produced on a registered valid/ready output.
- A sticky fault map, a saturating fault counter and a consecutive-fault alarm FSM are maintained.
- Sits between the BCD datapath under test and the self-test/status register block.

Parameters:
- DIGITS, 4, number of BCD digits per word (≥1).
- THRESH, 3, consecutive faulty words needed to enter FAULTY (≥1).
- CNT_W, 16, width of the saturating faulty-word counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word
- din  input  4*DIGITS  BCD word, digit k at [4k+3:4k]
- q  input  4*DIGITS  observed excess-3 output of the converter under test
- clr  input  1  synchronous clear of sticky map, counter and FSM
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- dout  output  4*DIGITS  expected excess-3 word
- sa0_map  output  4*DIGITS  bit=1: expected 1, observed 0
- sa1_map  output  4*DIGITS  bit=1: expected 0, observed 1 (zero without macro)
- bad_digit  output  DIGITS  digit >9 in din
- fault_sticky  output  4*DIGITS  OR of all sa0_map (and sa1_map) since reset/clr
- fault_cnt  output  CNT_W  count of faulty words, saturating at all-ones
- state  output  2  00 OK, 01 SUSPECT, 10 FAULTY
- alarm  output  1  state==FAULTY

Behaviour:
- Reset (rst_n low, async): out_valid=0; dout, sa0_map, sa1_map, bad_digit, fault_sticky, fault_cnt all 0; state=OK; alarm=0.
- Handshake: in_ready = !out_valid | out_ready (combinational).
  - Accept when in_valid & in_ready. Results are registered, latency 1 cycle.
  - Outputs hold stable while out_valid & !out_ready.
  - out_valid drops after a transfer with no new accept.
- Per digit k, valid (d≤9): dout digit = d+3 (4-bit, no carry between digits).
  - sa0 bits = dout & ~q; sa1 bits = ~dout & q.
- Invalid digit (d>9): dout digit=0000, that digit's sa0/sa1 bits forced 0, bad_digit[k]=1.
  - A bad digit does not count as a fault and does not change the FSM.
- A word is faulty iff any sa0 bit (or sa1 bit, if enabled) is set.
- The following update on accept only:
  - fault_sticky |= maps.
  - fault_cnt increments on a faulty word, holding at 2^CNT_W-1.
- FSM, with internal consecutive counter run:
  - OK: faulty → run=1. Go to SUSPECT, or straight to FAULTY if THRESH==1.
  - SUSPECT: faulty → run+1, and enter FAULTY when run reaches THRESH. Clean word (no faults, no bad digits) → OK, run=0. Word with only bad digits → stay, run unchanged.
  - FAULTY: sticky until clr or reset.
- clr:
  - Clears fault_sticky, fault_cnt, run and state to OK on the next edge.
  - If clr coincides with an accept, clr wins for the sticky, counter and FSM state.
  - The accepted word's maps still appear on the outputs.
  - clr does not affect out_valid or the data outputs.
- Reset mid-transfer: the pending result is discarded and out_valid goes to 0 immediately.

Optional Feature:
- Macro SA1_DETECT_EN.
- Defined: sa1_map is computed and contributes to fault_sticky, fault_cnt and the FSM.
- Undefined: sa1_map is tied to 0 and only SA0 faults are detected. Port list is unchanged.

Decomposition:
- Package bcd_ex3_pkg holds:
  - State enum (OK, SUSPECT, FAULTY) and its 2-bit encoding.
  - Constant EX3_OFFSET=4'd3 and BCD_MAX=4'd9.
- Sub-module bcd_ex3_digit: combinational per-digit expected value, sa0/sa1 bits and bad flag. It is instantiated DIGITS times via generate.

Test Plan:
- Clean word: din=0x0049, q=0x337C → dout=0x337C, sa0_map=0, state=OK, fault_cnt=0.
- Single SA0: din=0x0049, q=0x3378 → sa0_map=0x0004, fault_sticky=0x0004, fault_cnt=1, state=SUSPECT. Then a clean word → state=OK, sticky stays 0x0004.
- Alarm: 3 consecutive faulty words (din=0x1234, q=0x4467 each, sa0_map=0x0100) → state goes SUSPECT, SUSPECT, FAULTY with alarm=1. A following clean word leaves FAULTY. Pulsing clr → state=OK, fault_cnt=0, sticky=0.
- Bad digit: din=0x00A5, q=0x0008 → bad_digit=0b0010, dout=0x3308 (digits 2 and 3 are 0 → 3), no fault counted from digit 1. Digits 2/3 give sa0 bits 0x3300.
- Backpressure: hold out_ready=0 with 2 words offered → in_ready=0 after the first accept and outputs stable. Release → second word delivered one cycle after acceptance with no loss or duplication.
- SA1_DETECT_EN defined: din=0x0000, q=0x3337 → sa1_map=0x0004, word faulty. Without the macro → sa1_map=0 and fault_cnt=0.
